// File: rtl/fpu8_rr_sched_pkg.sv
// Shared definitions for the FPU_8 round-robin scheduler: opcode/exception codes,
// scheduler state encoding and the requester-ID width helper.
package fpu8_rr_sched_pkg;

  localparam logic [1:0] FPU_OP_ADD = 2'd0;
  localparam logic [1:0] FPU_OP_SUB = 2'd1;
  localparam logic [1:0] FPU_OP_MUL = 2'd2;
  localparam logic [1:0] FPU_OP_DIV = 2'd3;

  localparam logic [1:0] FPU_EXC_NONE = 2'd0;
  localparam logic [1:0] FPU_EXC_OVF  = 2'd1;
  localparam logic [1:0] FPU_EXC_UNF  = 2'd2;
  localparam logic [1:0] FPU_EXC_INV  = 2'd3;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Keeps the ID field at least one bit wide even for degenerate requester counts.
  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/fpu8_rr_sched_if.sv
// Bus interfaces of the scheduler: requester/response fabric and the FPU_8 datapath.
interface fpu8_req_if #(parameter int N_REQ = 4) ();
  localparam int ID_W = fpu8_rr_sched_pkg::id_width(N_REQ);

  logic [N_REQ-1:0]   valid;
  logic [N_REQ-1:0]   ready;
  logic [8*N_REQ-1:0] op_a;
  logic [8*N_REQ-1:0] op_b;
  logic [2*N_REQ-1:0] operation;
  logic [N_REQ-1:0]   round;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [7:0]         rsp_result;
  logic               rsp_is_exc;
  logic [1:0]         rsp_exc;

  modport master (
    output valid, op_a, op_b, operation, round, rsp_ready,
    input  ready, rsp_valid, rsp_id, rsp_result, rsp_is_exc, rsp_exc
  );

  modport slave (
    input  valid, op_a, op_b, operation, round, rsp_ready,
    output ready, rsp_valid, rsp_id, rsp_result, rsp_is_exc, rsp_exc
  );
endinterface

interface fpu8_fpu_if ();
  logic       fp_start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] fp_operation;
  logic       fp_round_mode;
  logic [7:0] op_result;
  logic       op_is_exception;
  logic [1:0] fp_exception;

  modport master (
    output fp_start, op_a, op_b, fp_operation, fp_round_mode,
    input  op_result, op_is_exception, fp_exception
  );

  modport slave (
    input  fp_start, op_a, op_b, fp_operation, fp_round_mode,
    output op_result, op_is_exception, fp_exception
  );
endinterface

// File: rtl/fpu8_rr_sched_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping
// N_REQ-1 -> 0; works for any N_REQ, power of two or not.
module fpu8_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant_idx  = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu8_rr_sched.sv
// Round-robin scheduler sharing one FPU_8 between N_REQ requesters, one op in flight.
// Optional exception counter output exc_count enabled by FPU8_SCHED_EXC_CNT_EN.
//
// state    | meaning
// ST_IDLE  | arbitrate; req.ready one-hot to winner, operands latched on accept
// ST_ISSUE | fp_start high for this single cycle, latency counter loaded
// ST_WAIT  | count down FPU latency, capture result when counter reaches 0
// ST_RESP  | response held on rsp_* until rsp_ready, then ptr moves past owner
module fpu8_rr_sched
  import fpu8_rr_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FPU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  fpu8_req_if.slave  req,
  fpu8_fpu_if.master fpu
`ifdef FPU8_SCHED_EXC_CNT_EN
  ,
  output logic [7:0] exc_count
`endif
);

  localparam int               ID_W     = id_width(N_REQ);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FPU_LAT - 1);

  sched_state_t     state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic [1:0]       sel_op;
  logic             sel_rnd;

  fpu8_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .valid     (req.valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Gated by rst so no requester sees an accept while reset is asserted.
  assign req.ready = (state == ST_IDLE && !rst) ? pick_grant : '0;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    sel_rnd = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == pick_idx) begin
        sel_a   = req.op_a[8*i +: 8];
        sel_b   = req.op_b[8*i +: 8];
        sel_op  = req.operation[2*i +: 2];
        sel_rnd = req.round[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      ptr               <= '0;
      cur_id            <= '0;
      cnt               <= '0;
      fpu.fp_start      <= 1'b0;
      fpu.op_a          <= '0;
      fpu.op_b          <= '0;
      fpu.fp_operation  <= '0;
      fpu.fp_round_mode <= 1'b0;
      req.rsp_valid     <= 1'b0;
      req.rsp_id        <= '0;
      req.rsp_result    <= '0;
      req.rsp_is_exc    <= 1'b0;
      req.rsp_exc       <= '0;
    end else begin
      fpu.fp_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            fpu.op_a          <= sel_a;
            fpu.op_b          <= sel_b;
            fpu.fp_operation  <= sel_op;
            fpu.fp_round_mode <= sel_rnd;
            cur_id            <= pick_idx;
            fpu.fp_start      <= 1'b1;
            state             <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            req.rsp_result <= fpu.op_result;
            req.rsp_is_exc <= fpu.op_is_exception;
            req.rsp_exc    <= fpu.fp_exception;
            req.rsp_id     <= cur_id;
            req.rsp_valid  <= 1'b1;
            state          <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (req.rsp_ready) begin
            req.rsp_valid <= 1'b0;
            ptr           <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FPU8_SCHED_EXC_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_count <= '0;
    end else if (req.rsp_valid && req.rsp_ready && req.rsp_is_exc && exc_count != 8'hFF) begin
      exc_count <= exc_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu8_rr_sched.sv
// Scoreboard bench for fpu8_rr_sched: random requesters, behavioural arbiter model,
// an FPU model whose outputs are only valid FPU_LAT cycles after fp_start.
module tb_fpu8_rr_sched;

  localparam int N         = 3;
  localparam int LAT       = 4;
  localparam int IW        = (N > 1) ? $clog2(N) : 1;
  localparam int SINGLE_ID = (N > 2) ? 2 : 1;
  localparam int M_NONE    = 0;
  localparam int M_SINGLE  = 1;
  localparam int M_FULL    = 2;
  localparam int M_RAND    = 3;
  localparam int M_EXC     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu8_req_if #(.N_REQ(N)) req_bus ();
  fpu8_fpu_if fpu_bus ();
`ifdef FPU8_SCHED_EXC_CNT_EN
  logic [7:0] exc_count;
`endif

  fpu8_rr_sched #(
    .N_REQ   (N),
    .FPU_LAT (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req_bus.slave),
    .fpu (fpu_bus.master)
`ifdef FPU8_SCHED_EXC_CNT_EN
    ,
    .exc_count (exc_count)
`endif
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       rnd;
    logic [7:0] res;
    logic       ie;
    logic [1:0] ec;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  int   acc_cyc = 0;
  int   exc_seen = 0;
  int   m_exc = 0;
  int   mode = M_NONE;
  int   rdy_mode = 1;
  int   rst_hold = 0;
  bit   busy = 1'b0;
  bit   go = 1'b0;
  bit   rst_req = 1'b0;
  bit   first_after_rst = 1'b0;
  bit   single_done = 1'b0;

  logic [7:0] pa[N];
  logic [7:0] pb[N];
  logic [1:0] pop[N];
  logic       pr[N];
  logic       pv[N];

  // Behavioural FPU: {is_exception, exception_code, result}
  function automatic logic [10:0] fpu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op, input logic rnd);
    logic [7:0] r;
    logic       e;
    logic [1:0] c;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a ^ b;
      default: r = {a[3:0], b[7:4]};
    endcase
    r = r + {7'd0, rnd};
    e = (a[7:6] == 2'b11);
    c = e ? 2'b10 : b[1:0];
    return {e, c, r};
  endfunction

  logic [4:0]  fpu_age;
  logic [10:0] fpu_val;
  always @(posedge clk or posedge rst) begin
    if (rst) fpu_age <= 5'd0;
    else if (fpu_bus.fp_start) fpu_age <= 5'd1;
    else if (fpu_age != 5'd0 && fpu_age != 5'd31) fpu_age <= fpu_age + 5'd1;
  end
  assign fpu_val = fpu_fn(fpu_bus.op_a, fpu_bus.op_b, fpu_bus.fp_operation, fpu_bus.fp_round_mode);
  assign {fpu_bus.op_is_exception, fpu_bus.fp_exception, fpu_bus.op_result} =
         (fpu_age >= 5'(LAT)) ? fpu_val : ~fpu_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},     32'(req_bus.ready),          32'd0);
    chk({tag, "_rsp_valid"},     32'(req_bus.rsp_valid),      32'd0);
    chk({tag, "_rsp_id"},        32'(req_bus.rsp_id),         32'd0);
    chk({tag, "_rsp_result"},    32'(req_bus.rsp_result),     32'd0);
    chk({tag, "_rsp_is_exc"},    32'(req_bus.rsp_is_exc),     32'd0);
    chk({tag, "_rsp_exc"},       32'(req_bus.rsp_exc),        32'd0);
    chk({tag, "_fp_start"},      32'(fpu_bus.fp_start),       32'd0);
    chk({tag, "_op_a"},          32'(fpu_bus.op_a),           32'd0);
    chk({tag, "_op_b"},          32'(fpu_bus.op_b),           32'd0);
    chk({tag, "_fp_operation"},  32'(fpu_bus.fp_operation),   32'd0);
    chk({tag, "_fp_round_mode"}, 32'(fpu_bus.fp_round_mode),  32'd0);
`ifdef FPU8_SCHED_EXC_CNT_EN
    chk({tag, "_exc_count"},     32'(exc_count),              32'd0);
`endif
  endtask

  task automatic pack_bus();
    for (int i = 0; i < N; i++) begin
      req_bus.valid[i]           = pv[i];
      req_bus.op_a[8*i +: 8]     = pa[i];
      req_bus.op_b[8*i +: 8]     = pb[i];
      req_bus.operation[2*i +: 2] = pop[i];
      req_bus.round[i]           = pr[i];
    end
  endtask

  function automatic bit any_pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (pv[i]) p = 1'b1;
    return p;
  endfunction

  initial forever @(posedge clk) cyc = cyc + 1;

  // Driver: requester fabric plus the arbitration reference model.
  initial begin : driver
    int              rel;
    int              prev_acc;
    int              w;
    logic [N-1:0]    exp_rdy;
    logic [10:0]     r;
    rel      = -1;
    prev_acc = -1;
    wait (go);
    forever begin
      @(negedge clk);
      if (rel >= 0) begin
        pv[rel] = 1'b0;
        rel     = -1;
      end
      case (rdy_mode)
        0:       req_bus.rsp_ready = ($urandom_range(0, 9) < 7);
        1:       req_bus.rsp_ready = 1'b1;
        default: req_bus.rsp_ready = 1'b0;
      endcase
      for (int i = 0; i < N; i++) begin
        if (!pv[i]) begin
          logic raise;
          case (mode)
            M_SINGLE:      raise = (i == SINGLE_ID) && !single_done;
            M_FULL, M_EXC: raise = 1'b1;
            M_RAND:        raise = ($urandom_range(0, 9) < 3);
            default:       raise = 1'b0;
          endcase
          if (raise) begin
            pv[i]  = 1'b1;
            pa[i]  = 8'($urandom);
            pb[i]  = 8'($urandom);
            pop[i] = 2'($urandom);
            pr[i]  = 1'($urandom);
            if (mode == M_EXC) pa[i][7:6] = 2'b11;
            if (mode == M_SINGLE) begin
              pa[i]       = 8'h38;
              pb[i]       = 8'h40;
              pop[i]      = 2'b00;
              pr[i]       = 1'b0;
              single_done = 1'b1;
            end
          end
        end
      end
      pack_bus();
      if (rst_req && busy && cyc == acc_cyc + 3) begin
        rst = 1'b1;
        #1;
        chk_zero("mid_wait_rst");
        busy            = 1'b0;
        m_ptr           = 0;
        m_exc           = 0;
        sbq.delete();
        rst_req         = 1'b0;
        rst_hold        = 2;
        first_after_rst = 1'b1;
        prev_acc        = -1;
      end else if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end
      #1;
      if (!(mode == M_FULL && rdy_mode == 1)) prev_acc = -1;
      exp_rdy = '0;
      w       = -1;
      if (!rst && !busy) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (w < 0 && pv[i]) w = i;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(req_bus.ready), 32'(exp_rdy));
      if (w >= 0 && req_bus.ready === exp_rdy) begin
        if (first_after_rst) begin
          chk("first_grant_after_rst", 32'(req_bus.ready[0]), 32'd1);
          first_after_rst = 1'b0;
        end
        if (mode == M_FULL && rdy_mode == 1) begin
          if (prev_acc >= 0) chk("grant_spacing", 32'(cyc - prev_acc), 32'(LAT + 3));
          prev_acc = cyc;
        end
        r = fpu_fn(pa[w], pb[w], pop[w], pr[w]);
        sbq.push_back('{id: w, a: pa[w], b: pb[w], op: pop[w], rnd: pr[w],
                        res: r[7:0], ie: r[10], ec: r[9:8]});
        busy    = 1'b1;
        acc_cyc = cyc;
        rel     = w;
      end
    end
  end

  // Monitor: checks FPU issue and the response channel against the scoreboard.
  initial begin : monitor
    logic exp_start;
    logic exp_valid;
    exp_t e;
    wait (go);
    forever begin
      @(negedge clk);
      #3;
      exp_start = busy && (cyc == acc_cyc + 1);
      chk("fp_start", 32'(fpu_bus.fp_start), 32'(exp_start));
      exp_valid = busy && (cyc >= acc_cyc + LAT + 2);
      chk("rsp_valid", 32'(req_bus.rsp_valid), 32'(exp_valid));
`ifdef FPU8_SCHED_EXC_CNT_EN
      chk("exc_count", 32'(exc_count), 32'(m_exc));
`endif
      if (sbq.size() > 0) begin
        e = sbq[0];
        if (fpu_bus.fp_start) begin
          chk("fpu_op_a", 32'(fpu_bus.op_a), 32'(e.a));
          chk("fpu_op_b", 32'(fpu_bus.op_b), 32'(e.b));
          chk("fpu_operation", 32'(fpu_bus.fp_operation), 32'(e.op));
          chk("fpu_round", 32'(fpu_bus.fp_round_mode), 32'(e.rnd));
        end
        if (req_bus.rsp_valid) begin
          chk("rsp_id", 32'(req_bus.rsp_id), 32'(e.id));
          chk("rsp_id_range", 32'(int'(req_bus.rsp_id) < N), 32'd1);
          chk("rsp_result", 32'(req_bus.rsp_result), 32'(e.res));
          chk("rsp_is_exc", 32'(req_bus.rsp_is_exc), 32'(e.ie));
          chk("rsp_exc", 32'(req_bus.rsp_exc), 32'(e.ec));
          if (req_bus.rsp_ready) begin
            void'(sbq.pop_front());
            m_ptr = (e.id + 1) % N;
            busy  = 1'b0;
            if (e.ie) begin
              exc_seen++;
              if (m_exc < 255) m_exc++;
            end
          end
        end
      end
    end
  end

  initial begin : main
    for (int i = 0; i < N; i++) begin
      pv[i]  = 1'b0;
      pa[i]  = '0;
      pb[i]  = '0;
      pop[i] = '0;
      pr[i]  = 1'b0;
    end
    req_bus.rsp_ready = 1'b0;
    pack_bus();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    go = 1'b1;

    @(posedge clk);
    mode     = M_SINGLE;
    rdy_mode = 1;
    repeat (20) @(posedge clk);

    mode = M_FULL;
    repeat (4 * N * (LAT + 3)) @(posedge clk);

    rdy_mode = 2;
    repeat (12) @(posedge clk);
    rdy_mode = 1;
    repeat (3 * (LAT + 3)) @(posedge clk);

    mode     = M_RAND;
    rdy_mode = 0;
    repeat (800) @(posedge clk);

    mode     = M_EXC;
    rdy_mode = 1;
    for (int k = 0; k < 6000 && exc_seen < 300; k++) @(posedge clk);
    chk("exc_phase_done", 32'(exc_seen >= 300), 32'd1);
`ifdef FPU8_SCHED_EXC_CNT_EN
    @(posedge clk);
    #2 chk("exc_count_saturated", 32'(exc_count), 32'hFF);
`endif

    @(posedge clk);
    mode    = M_FULL;
    rst_req = 1'b1;
    for (int k = 0; k < 200 && (rst_req || rst_hold != 0); k++) @(posedge clk);
    chk("mid_wait_rst_done", 32'(rst_req || rst_hold != 0), 32'd0);
    repeat (50) @(posedge clk);

    mode     = M_RAND;
    rdy_mode = 0;
    repeat (400) @(posedge clk);

    mode     = M_NONE;
    rdy_mode = 1;
    for (int k = 0; k < 100 * N && (busy || any_pending()); k++) @(posedge clk);
    chk("drain", 32'(busy || any_pending()), 32'd0);
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu8_rr_sched.md
Name: fpu8_rr_sched

Overview:
Round-robin scheduler that shares one FPU_8 instance between N_REQ requesters.
- Each requester presents one operation (operands, opcode, round mode) with a valid/ready handshake.
- The scheduler grants one requester, drives the FPU operand/control inputs and pulses FP_Start.
- It waits FPU_LAT cycles, captures result and exception flags, and returns them on a single response channel tagged with the requester ID.
- It sits between the requester fabric and the FPU_8/EXCEPTION_MODULE datapath.

Parameters:
N_REQ, 4, number of requesters (2..8, need not be a power of two)
FPU_LAT, 1, cycles from FP_Start pulse to result valid at FPU outputs (1..15)
ID_W, $clog2(N_REQ), derived width of requester ID; not overridden

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
REQ_VALID  in  N_REQ  per-requester request valid
REQ_READY  out  N_REQ  per-requester accept (one-hot or zero)
REQ_OP_A  in  8*N_REQ  packed operand A, requester i at [8i+7:8i]
REQ_OP_B  in  8*N_REQ  packed operand B
REQ_OPERATION  in  2*N_REQ  packed FPU opcode
REQ_ROUND  in  N_REQ  per-requester round mode
RSP_VALID  out  1  response valid
RSP_READY  in  1  response accept
RSP_ID  out  ID_W  index of the requester owning the response
RSP_RESULT  out  8  captured OP_RESULT
RSP_IS_EXC  out  1  captured OP_IS_EXCEPTION
RSP_EXC  out  2  captured FP_Exception code
FP_Start  out  1  start pulse to FPU
OP_A, OP_B  out  8 each  operands to FPU
FP_OPERATION  out  2  opcode to FPU
FP_ROUND_MODE  out  1  round mode to FPU
OP_RESULT  in  8  FPU result
OP_IS_EXCEPTION  in  1  FPU exception flag
FP_Exception  in  2  FPU exception code

Behaviour:
- **Reset:** RST high, asynchronous. Effects:
  - State goes to IDLE and rr pointer to 0.
  - REQ_READY, RSP_VALID, RSP_ID, RSP_RESULT, RSP_IS_EXC, RSP_EXC, FP_Start, OP_A, OP_B, FP_OPERATION and FP_ROUND_MODE all go to 0.
  - An in-flight transaction is discarded and no response is issued.
- **FSM** states are IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Winner g is the first i with REQ_VALID[i], searching from ptr upward and wrapping N_REQ-1 -> 0.
  - REQ_READY[g] is driven combinationally in IDLE only. All other bits are 0.
  - On the edge, latch operands, opcode, round and g into operand registers. Go to ISSUE.
  - No valid request means stay in IDLE with REQ_READY all 0.
- **ISSUE:**
  - FP_Start=1 for exactly this cycle.
  - OP_A/OP_B/FP_OPERATION/FP_ROUND_MODE come from registers and stay stable through WAIT.
  - Load cnt=FPU_LAT-1 and go to WAIT.
- **WAIT:**
  - Decrement cnt.
  - When cnt==0, capture OP_RESULT/OP_IS_EXCEPTION/FP_Exception into the RSP_* registers and go to RESP.
- **RESP:**
  - RSP_VALID=1. RSP_* are held stable until RSP_READY.
  - On RSP_VALID&&RSP_READY: ptr = (g==N_REQ-1) ? 0 : g+1, RSP_VALID drops next cycle, and the FSM returns to IDLE.
- **Latency:**
  - Accept at edge t, FP_Start high in cycle t+1, capture at edge t+1+FPU_LAT, RSP_VALID high from cycle t+2+FPU_LAT.
  - Minimum per-op occupancy is FPU_LAT+3 cycles.
- **Single outstanding operation:**
  - REQ_READY stays 0 in ISSUE/WAIT/RESP.
  - Requesters must hold REQ_VALID and payload until accepted.
  - A requester dropping VALID before grant simply loses arbitration; there is no error.
- **Fairness:** a requester that keeps VALID high waits at most N_REQ-1 grants. ptr advances only on response completion.
- **Response backpressure:** RSP_READY low holds RESP indefinitely. No new request is accepted meanwhile.
- **Opcode:** the 2-bit value is passed through without decode. Exception flags are passed through unmodified.

Optional Feature:
FPU8_SCHED_EXC_CNT_EN
- **Defined:**
  - Adds output EXC_COUNT[7:0], reset 0.
  - Increments by 1 on each response handshake with RSP_IS_EXC=1.
  - Saturates at 8'hFF.
- **Undefined:** port and counter are absent, with no other behavioural change.

Decomposition:
- **Shared package FPU_PACK:**
  - FPU opcode localparams (2-bit).
  - Exception-code localparams (2-bit).
  - Scheduler state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
- **One sub-module, fpu8_rr_pick:** combinational round-robin priority picker. Inputs: valid vector and ptr. Outputs: one-hot grant and grant index.

Test Plan:
- **Single request:** N_REQ=4, FPU_LAT=1, REQ_VALID=4'b0100 with OP_A=8'h38, OP_B=8'h40, OP=2'b00, RSP_READY=1. Require:
  - REQ_READY=4'b0100 in the same cycle.
  - FP_Start for one cycle with OP_A=8'h38.
  - RSP_VALID 3 cycles after accept with RSP_ID=2, RSP_RESULT equal to the FPU model output.
- **Round-robin:** REQ_VALID=4'b1111 held, RSP_READY=1. Grant order is 0,1,2,3,0, and each grant is separated by FPU_LAT+3 cycles.
- **Backpressure:** RSP_READY=0 for 10 cycles. Require RSP_VALID and RSP_* stable, REQ_READY=0 throughout, and the next grant only after RSP_READY=1.
- **Exception passthrough:** FPU model returns OP_IS_EXCEPTION=1, FP_Exception=2'b10. Require RSP_IS_EXC=1 and RSP_EXC=2'b10. With FPU8_SCHED_EXC_CNT_EN, EXC_COUNT goes 0->1, and 300 exceptions leave it saturated at 8'hFF.
- **Reset mid-WAIT:** FPU_LAT=5, assert RST in WAIT cycle 2. Require all outputs 0 immediately (asynchronous), no response ever issued, and after release a requester 0 request is granted first.
- **Non-power-of-two:** N_REQ=3, REQ_VALID=3'b111. Require ptr wraps 2->0, RSP_ID never equals 3, and fpu8_rr_pick never produces a grant of 3.
